exc_cp0_ctrl: RTL and testbench

Parametrised exception/interrupt controller for the MIPS pipeline: it accepts the merged exception code and PC of the instruction in M, samples a configurable number of hardware interrupt lines, and decides whether to take an exception this cycle. It also holds the architectural SR/Cause/EPC/PRId state, serves mtc0/mfc0 from M, and handles eret. It sits at the M stage, replaces the old purely combinational M-stage exception merge, and drives the pipeline-wide flush and handler redirect.

---
 rtl/exc_cp0_ctrl.sv | 143 ++++++++++++++
 tb/tb_exc_cp0_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_cp0_ctrl.sv
// M-stage exception/interrupt controller with SR/Cause/EPC/PRId state, mtc0/mfc0 and eret.
// Optional macro EXC_BD_EN: honour bd_m (EPC <= pc_m - 4, Cause.BD) for delay-slot faults.
module exc_cp0_ctrl #(
    parameter int unsigned NUM_HWINT  = 6,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID       = 32'h2021_0007
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4:0]           exc_code_m,
    input  logic [31:0]          pc_m,
    input  logic                 valid_m,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 cp0_we,
    input  logic [4:0]           cp0_addr,
    input  logic [31:0]          cp0_wdata,
    input  logic                 eret_m,
    input  logic                 bd_m,
    output logic [31:0]          cp0_rdata,
    output logic                 exc_req,
    output logic [31:0]          exc_target,
    output logic [31:0]          epc_out,
    output logic                 exl_out
);

    localparam int IM_LSB = 10;

    localparam logic [0:0] ST_NORMAL  = 1'b0;
    localparam logic [0:0] ST_HANDLER = 1'b1;

    logic [0:0]           state_q, state_d;
    logic                 ie_q, ie_d;
    logic [NUM_HWINT-1:0] im_q, im_d;
    logic [NUM_HWINT-1:0] ip_q;
    logic [4:0]           exccode_q, exccode_d;
    logic                 bd_q, bd_d;
    logic [31:0]          epc_q, epc_d;

    logic        exl;
    logic        int_pend;
    logic        exc_pend;
    logic [31:0] epc_new;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic        unused_ok;

    // Only some write-data bits map to fields; bd_m is dead in the default build.
    assign unused_ok = ^{cp0_wdata, bd_m};

    assign exl      = (state_q == ST_HANDLER);
    assign int_pend = ie_q & ~exl & (|(hwint & im_q));
    assign exc_pend = valid_m & (exc_code_m != 5'd0) & ~exl;
    assign exc_req  = int_pend | exc_pend;

    assign exc_target = exc_req ? HANDLER_PC : epc_q;
    assign epc_out    = epc_q;
    assign exl_out    = exl;

    always_comb begin
        epc_new = pc_m;
`ifdef EXC_BD_EN
        if (bd_m) epc_new = pc_m - 32'd4;
`endif
        // A misaligned fetch faults on the PC itself; resume from the enclosing word.
        if (exc_pend && !int_pend && exc_code_m == 5'd4) epc_new[1:0] = 2'b00;
    end

    always_comb begin
        sr_val                        = '0;
        sr_val[IM_LSB +: NUM_HWINT]   = im_q;
        sr_val[1]                     = exl;
        sr_val[0]                     = ie_q;
        cause_val                     = '0;
        cause_val[31]                 = bd_q;
        cause_val[IM_LSB +: NUM_HWINT] = ip_q;
        cause_val[6:2]                = exccode_q;
    end

    always_comb begin
        case (cp0_addr)
            5'd12:   cp0_rdata = sr_val;
            5'd13:   cp0_rdata = cause_val;
            5'd14:   cp0_rdata = epc_q;
            5'd15:   cp0_rdata = PRID;
            default: cp0_rdata = '0;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal starts from its current value, so no path leaves it unassigned (no latches).
        state_d   = state_q;
        ie_d      = ie_q;
        im_d      = im_q;
        exccode_d = exccode_q;
        bd_d      = bd_q;
        epc_d     = epc_q;
        if (exc_req) begin
            state_d   = ST_HANDLER;
            exccode_d = int_pend ? 5'd0 : exc_code_m;
            epc_d     = epc_new;
`ifdef EXC_BD_EN
            bd_d      = bd_m;
`else
            bd_d      = 1'b0;
`endif
        end else begin
            if (cp0_we) begin
                case (cp0_addr)
                    5'd12: begin
                        im_d    = cp0_wdata[IM_LSB +: NUM_HWINT];
                        state_d = cp0_wdata[1];
                        ie_d    = cp0_wdata[0];
                    end
                    5'd14:   epc_d = cp0_wdata;
                    default: ;
                endcase
            end
            if (eret_m) state_d = ST_NORMAL;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_NORMAL;
            ie_q      <= 1'b0;
            im_q      <= '0;
            ip_q      <= '0;
            exccode_q <= 5'd0;
            bd_q      <= 1'b0;
            epc_q     <= '0;
        end else begin
            state_q   <= state_d;
            ie_q      <= ie_d;
            im_q      <= im_d;
            ip_q      <= hwint;
            exccode_q <= exccode_d;
            bd_q      <= bd_d;
            epc_q     <= epc_d;
        end
    end

endmodule

// File: tb/tb_exc_cp0_ctrl.sv
// Self-checking bench for exc_cp0_ctrl: directed vector table, mid-handler reset, random vs. model.
module tb_exc_cp0_ctrl;

    localparam logic [31:0] HPC  = 32'h0000_4180;
    localparam logic [31:0] PRID = 32'h2021_0007;
`ifdef EXC_BD_EN
    localparam bit BD_EN = 1'b1;
`else
    localparam bit BD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  exc_code_m;
    logic [31:0] pc_m;
    logic        valid_m;
    logic [5:0]  hwint;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        eret_m;
    logic        bd_m;
    logic [31:0] cp0_rdata;
    logic        exc_req;
    logic [31:0] exc_target;
    logic [31:0] epc_out;
    logic        exl_out;

    int n_cmp = 0;
    int n_bad = 0;

    exc_cp0_ctrl dut (
        .clk(clk), .reset_n(reset_n), .exc_code_m(exc_code_m), .pc_m(pc_m),
        .valid_m(valid_m), .hwint(hwint), .cp0_we(cp0_we), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .eret_m(eret_m), .bd_m(bd_m), .cp0_rdata(cp0_rdata),
        .exc_req(exc_req), .exc_target(exc_target), .epc_out(epc_out), .exl_out(exl_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  code;
        logic [31:0] pc;
        logic [5:0]  hw;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        eret;
        logic        bd;
        logic        e_req;
        logic [31:0] e_target;
        logic [31:0] e_rdata;
        logic        e_exl;
        logic [31:0] e_epc;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic valid, input logic [4:0] code, input logic [31:0] pc,
                                input logic [5:0] hw, input logic we, input logic [4:0] addr,
                                input logic [31:0] wdata, input logic eret, input logic bd,
                                input logic e_req, input logic [31:0] e_target,
                                input logic [31:0] e_rdata, input logic e_exl,
                                input logic [31:0] e_epc);
        vec_t v;
        v.valid = valid; v.code = code; v.pc = pc; v.hw = hw; v.we = we; v.addr = addr;
        v.wdata = wdata; v.eret = eret; v.bd = bd; v.e_req = e_req; v.e_target = e_target;
        v.e_rdata = e_rdata; v.e_exl = e_exl; v.e_epc = e_epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_m = 0; exc_code_m = 0; pc_m = 0; hwint = 0; cp0_we = 0;
        cp0_addr = 0; cp0_wdata = 0; eret_m = 0; bd_m = 0;
    endtask

    // Architectural model of the CP0 state
    logic       m_ie, m_exl, m_bd;
    logic [5:0] m_im, m_ip;
    logic [4:0] m_code;
    logic [31:0] m_epc;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13:   return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_code) << 2);
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] e18, c18, e21, c21;
        e18 = BD_EN ? 32'h0000_32FC : 32'h0000_3300;
        c18 = BD_EN ? 32'h8000_0010 : 32'h0000_0010;
        e21 = BD_EN ? 32'h0000_3040 : 32'h0000_3044;
        c21 = BD_EN ? 32'h8000_0030 : 32'h0000_0030;

        //            v  code pc          hw we addr wdata        er bd  req tgt          rdata        exl epc
        tbl[0]  = mk(0, 0,  32'h0,      1, 0, 13, 32'h0,        0, 0,  0, 32'h0,       32'h400,      0, 32'h0);
        tbl[1]  = mk(0, 0,  32'h0,      0, 1, 12, 32'h401,      0, 0,  0, 32'h0,       32'h0,        0, 32'h0);
        tbl[2]  = mk(0, 0,  32'h3010,   1, 0, 12, 32'h0,        0, 0,  1, HPC,         32'h401,      0, 32'h0);
        tbl[3]  = mk(1, 10, 32'h3014,   1, 0, 13, 32'h0,        0, 0,  0, 32'h3010,    32'h400,      1, 32'h3010);
        tbl[4]  = mk(0, 0,  32'h0,      0, 0, 14, 32'h0,        1, 0,  0, 32'h3010,    32'h3010,     1, 32'h3010);
        tbl[5]  = mk(0, 0,  32'h0,      0, 1, 12, 32'h0,        0, 0,  0, 32'h3010,    32'h401,      0, 32'h3010);
        tbl[6]  = mk(1, 12, 32'h3020,   0, 0, 13, 32'h0,        0, 0,  1, HPC,         32'h0,        0, 32'h3010);
        tbl[7]  = mk(1, 10, 32'h3024,   0, 0, 13, 32'h0,        0, 0,  0, 32'h3020,    32'h30,       1, 32'h3020);
        tbl[8]  = mk(0, 0,  32'h0,      0, 0, 14, 32'h0,        1, 0,  0, 32'h3020,    32'h3020,     1, 32'h3020);
        tbl[9]  = mk(1, 10, 32'h3030,   0, 1, 14, 32'h5555_0000, 0, 0, 1, HPC,         32'h3020,     0, 32'h3020);
        tbl[10] = mk(0, 0,  32'h0,      0, 0, 14, 32'h0,        0, 0,  0, 32'h3030,    32'h3030,     1, 32'h3030);
        tbl[11] = mk(0, 0,  32'h0,      0, 1, 14, 32'h3100,     0, 0,  0, 32'h3030,    32'h3030,     1, 32'h3030);
        tbl[12] = mk(0, 0,  32'h0,      0, 0, 14, 32'h0,        1, 0,  0, 32'h3100,    32'h3100,     1, 32'h3100);
        tbl[13] = mk(0, 0,  32'h0,      0, 1, 12, 32'h401,      0, 0,  0, 32'h3100,    32'h0,        0, 32'h3100);
        tbl[14] = mk(0, 0,  32'h3200,   1, 0, 12, 32'h0,        1, 0,  1, HPC,         32'h401,      0, 32'h3100);
        tbl[15] = mk(0, 0,  32'h0,      0, 0, 15, 32'h0,        0, 0,  0, 32'h3200,    PRID,         1, 32'h3200);
        tbl[16] = mk(0, 0,  32'h0,      0, 0, 13, 32'h0,        1, 0,  0, 32'h3200,    32'h0,        1, 32'h3200);
        tbl[17] = mk(1, 4,  32'h3302,   0, 0, 3,  32'h0,        0, 1,  1, HPC,         32'h0,        0, 32'h3200);
        tbl[18] = mk(0, 0,  32'h0,      0, 0, 13, 32'h0,        0, 0,  0, e18,         c18,          1, e18);
        tbl[19] = mk(0, 0,  32'h0,      0, 0, 14, 32'h0,        1, 0,  0, e18,         e18,          1, e18);
        tbl[20] = mk(1, 12, 32'h3044,   0, 0, 13, 32'h0,        0, 1,  1, HPC,         c18,          0, e18);
        tbl[21] = mk(0, 0,  32'h0,      0, 0, 13, 32'h0,        0, 0,  0, e21,         c21,          1, e21);
        tbl[22] = mk(0, 0,  32'h0,      0, 1, 3,  32'hFFFF_FFFF, 0, 0, 0, e21,         32'h0,        1, e21);
        tbl[23] = mk(0, 0,  32'h0,      0, 0, 12, 32'h0,        0, 0,  0, e21,         32'h403,      1, e21);

        // Reset with an interrupt line high and SR cleared
        idle_inputs();
        hwint   = 6'b000001;
        reset_n = 1'b0;
        #12;
        check("reset exc_req", 32'(exc_req), 32'd0);
        check("reset exl_out", 32'(exl_out), 32'd0);
        check("reset epc_out", epc_out, 32'd0);
        for (int a = 12; a <= 14; a++) begin
            cp0_addr = 5'(a);
            #1 check($sformatf("reset rdata a%0d", a), cp0_rdata, 32'd0);
        end
        cp0_addr = 0;
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            valid_m = tbl[i].valid; exc_code_m = tbl[i].code; pc_m = tbl[i].pc;
            hwint = tbl[i].hw; cp0_we = tbl[i].we; cp0_addr = tbl[i].addr;
            cp0_wdata = tbl[i].wdata; eret_m = tbl[i].eret; bd_m = tbl[i].bd;
            #1;
            check($sformatf("row%0d exc_req", i), 32'(exc_req), 32'(tbl[i].e_req));
            check($sformatf("row%0d exc_target", i), exc_target, tbl[i].e_target);
            check($sformatf("row%0d cp0_rdata", i), cp0_rdata, tbl[i].e_rdata);
            check($sformatf("row%0d exl_out", i), 32'(exl_out), 32'(tbl[i].e_exl));
            check($sformatf("row%0d epc_out", i), epc_out, tbl[i].e_epc);
        end

        // Reset in the middle of a handler, away from any clock edge
        idle_inputs();
        #2 reset_n = 1'b0;
        #1;
        check("midreset exl_out", 32'(exl_out), 32'd0);
        check("midreset epc_out", epc_out, 32'd0);
        check("midreset exc_target", exc_target, 32'd0);
        cp0_addr = 5'd12;
        #1 check("midreset SR", cp0_rdata, 32'd0);
        cp0_addr = 5'd13;
        #1 check("midreset Cause", cp0_rdata, 32'd0);
        cp0_addr = 0;
        @(negedge clk);
        reset_n = 1'b1;

        m_ie = 0; m_exl = 0; m_bd = 0; m_im = 0; m_ip = 0; m_code = 0; m_epc = 0;

        for (int c = 0; c < 400; c++) begin
            logic ip, ep, rq;
            logic [31:0] e;
            @(negedge clk);
            valid_m    = ($urandom_range(0, 3) != 0);
            exc_code_m = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            pc_m       = $urandom;
            hwint      = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            cp0_we     = ($urandom_range(0, 3) == 0);
            cp0_addr   = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            cp0_wdata  = $urandom;
            eret_m     = !cp0_we && ($urandom_range(0, 3) == 0);
            bd_m       = $urandom_range(0, 1) != 0;
            #1;
            ip = m_ie && !m_exl && ((hwint & m_im) != 0);
            ep = valid_m && (exc_code_m != 0) && !m_exl;
            rq = ip || ep;
            check($sformatf("rnd%0d exc_req", c), 32'(exc_req), 32'(rq));
            check($sformatf("rnd%0d exc_target", c), exc_target, rq ? HPC : m_epc);
            check($sformatf("rnd%0d cp0_rdata", c), cp0_rdata, model_read(cp0_addr));
            check($sformatf("rnd%0d exl_out", c), 32'(exl_out), 32'(m_exl));
            check($sformatf("rnd%0d epc_out", c), epc_out, m_epc);
            if (rq) begin
                e = (BD_EN && bd_m) ? pc_m - 32'd4 : pc_m;
                if (!ip && exc_code_m == 5'd4) e = e & ~32'd3;
                m_epc  = e;
                m_exl  = 1'b1;
                m_code = ip ? 5'd0 : exc_code_m;
                m_bd   = BD_EN && bd_m;
            end else begin
                if (cp0_we && cp0_addr == 5'd12) begin
                    m_im  = cp0_wdata[15:10];
                    m_exl = cp0_wdata[1];
                    m_ie  = cp0_wdata[0];
                end
                if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_wdata;
                if (eret_m) m_exl = 1'b0;
            end
            m_ip = hwint;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
